// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer feeding a CP0 HWInt line.
// Register map on Addr[3:2]: 00 CTRL {IM, Mode[1:0], Enable}, 01 PRESET,
// 10 COUNT (read-only), 11 reserved (reads 0). Mode 01 auto-reloads and
// pulses the interrupt for one cycle; all other modes are one-shot with a
// held interrupt that is cleared by any CTRL write or the next LOAD.
module timer_counter #(
    parameter int unsigned PRESCALE = 1   // clock cycles per count tick, 1..65535
) (
    input  logic        clk,
    input  logic        reset,            // synchronous, active-low
    input  logic [31:0] Addr,
    input  logic        we,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CNT  = 2'b10,
        INT  = 2'b11
    } state_t;

    localparam logic [1:0]  MODE_AUTO = 2'b01;
    localparam logic [15:0] TICK_LAST = 16'(PRESCALE - 1);

    // Architectural registers
    state_t      r_state;
    logic        r_enable;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic [15:0] r_presc;
    logic        r_irq_flag;

    // Decode and FSM control strobes
    state_t      w_state_next;
    logic        w_ctrl_wr;
    logic        w_preset_wr;
    logic        w_tick;
    logic        w_count_last;
    logic        w_load;        // COUNT <= PRESET, prescaler restarts, flag clears
    logic        w_dec;         // tick with COUNT > 1
    logic        w_fire;        // tick with COUNT <= 1
    logic        w_presc_inc;   // non-tick counting cycle
    logic        w_en_clr;      // one-shot completion clears Enable

    // Only Addr[3:2] is decoded; the remaining bits are deliberately ignored.
    logic        w_unused_addr;
    assign w_unused_addr = ^{Addr[31:4], Addr[1:0]};

    assign w_ctrl_wr    = we && (Addr[3:2] == 2'b00);
    assign w_preset_wr  = we && (Addr[3:2] == 2'b01);
    assign w_tick       = (r_presc == TICK_LAST);
    assign w_count_last = (r_count <= 32'd1);

    // State register
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and datapath control strobes
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_fire       = 1'b0;
        w_presc_inc  = 1'b0;
        w_en_clr     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_enable) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_load       = 1'b1;
                w_state_next = CNT;
            end
            CNT: begin
                if (!r_enable) begin
                    w_state_next = IDLE;
                end else if (!w_tick) begin
                    w_presc_inc = 1'b1;
                end else if (!w_count_last) begin
                    w_dec = 1'b1;
                end else begin
                    w_fire       = 1'b1;
                    w_state_next = INT;
                end
            end
            INT: begin
                if (r_mode == MODE_AUTO) begin
                    w_load       = 1'b1;
                    w_state_next = CNT;
                end else begin
                    w_en_clr     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // CTRL and PRESET registers; a CPU CTRL write beats the one-shot Enable clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_enable <= 1'b0;
            r_mode   <= 2'b00;
            r_im     <= 1'b0;
            r_preset <= 32'd0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= Din[0];
                r_mode   <= Din[2:1];
                r_im     <= Din[3];
            end else if (w_en_clr) begin
                r_enable <= 1'b0;
            end
            if (w_preset_wr) begin
                r_preset <= Din;
            end
        end
    end

    // COUNT and prescaler; COUNT saturates at 0 because the last tick forces 0
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 32'd0;
            r_presc <= 16'd0;
        end else begin
            if (w_load) begin
                r_count <= r_preset;
            end else if (w_dec) begin
                r_count <= r_count - 32'd1;
            end else if (w_fire) begin
                r_count <= 32'd0;
            end

            if (w_load || w_dec || w_fire) begin
                r_presc <= 16'd0;
            end else if (w_presc_inc) begin
                r_presc <= r_presc + 16'd1;
            end
        end
    end

    // Interrupt flag; a CTRL write clears it even on the edge that would set it
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_irq_flag <= 1'b0;
        end else if (w_ctrl_wr || w_load) begin
            r_irq_flag <= 1'b0;
        end else if (w_fire) begin
            r_irq_flag <= 1'b1;
        end
    end

    // Read mux, side-effect free
    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            2'b00:   Dout = {28'd0, r_im, r_mode, r_enable};
            2'b01:   Dout = r_preset;
            2'b10:   Dout = r_count;
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = r_irq_flag & r_im;

endmodule
